// File: rtl/bp_cfg_loader.sv
`default_nettype none
// ============================================================================
// Module   : bp_cfg_loader
// Purpose  : Walks a per-configuration register table and broadcasts each
//            field to every core, holding the cores frozen until complete.
// Revision : 1.0
// ============================================================================
module bp_cfg_loader #(
    parameter int num_core_p       = 4,
    parameter int num_regs_p       = 8,
    parameter int cfg_data_width_p = 64,
    parameter int cfg_addr_width_p = 16,
    parameter int max_cfgs_p       = 16,
    parameter int num_cfgs_p       = 9,
    localparam int SEL_W  = (max_cfgs_p > 1) ? $clog2(max_cfgs_p) : 1,
    localparam int REG_W  = (num_regs_p > 1) ? $clog2(num_regs_p) : 1,
    localparam int CORE_W = (num_core_p > 1) ? $clog2(num_core_p) : 1
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic                        start_v_i,
    input  logic [SEL_W-1:0]            cfg_sel_i,
    output logic                        start_ready_o,
    output logic                        tbl_rd_v_o,
    output logic [SEL_W-1:0]            tbl_cfg_o,
    output logic [REG_W-1:0]            tbl_reg_o,
    input  logic [cfg_data_width_p-1:0] tbl_data_i,
    output logic                        cfg_v_o,
    output logic [CORE_W-1:0]           cfg_core_o,
    output logic [cfg_addr_width_p-1:0] cfg_addr_o,
    output logic [cfg_data_width_p-1:0] cfg_data_o,
    input  logic                        cfg_ready_i,
    output logic [num_core_p-1:0]       freeze_o,
    output logic                        done_o,
    output logic                        error_o
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SEND  = 3'd1,
        ST_READ  = 3'd2,
        ST_LATCH = 3'd3,
        ST_DONE  = 3'd4,
        ST_ERR   = 3'd5
    } state_t;

    state_t                      state, state_nxt;
    logic [SEL_W-1:0]            cfg_idx, cfg_idx_nxt;
    logic [REG_W-1:0]            reg_idx, reg_idx_nxt;
    logic [CORE_W-1:0]           core_idx, core_idx_nxt;
    logic [cfg_data_width_p-1:0] data_q, data_nxt;
    logic                        frozen, frozen_nxt;
    logic                        sel_bad, last_core, last_reg;

    // Index 0 is the reserved "no configuration" entry.
    assign sel_bad   = (cfg_sel_i == '0) || (32'(cfg_sel_i) >= 32'(num_cfgs_p));
    assign last_core = (core_idx == CORE_W'(num_core_p - 1));
    assign last_reg  = (reg_idx == REG_W'(num_regs_p - 1));

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state    <= ST_IDLE;
            cfg_idx  <= '0;
            reg_idx  <= '0;
            core_idx <= '0;
            data_q   <= '0;
            frozen   <= 1'b1;
        end else begin
            state    <= state_nxt;
            cfg_idx  <= cfg_idx_nxt;
            reg_idx  <= reg_idx_nxt;
            core_idx <= core_idx_nxt;
            data_q   <= data_nxt;
            frozen   <= frozen_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        cfg_idx_nxt   = cfg_idx;
        reg_idx_nxt   = reg_idx;
        core_idx_nxt  = core_idx;
        data_nxt      = data_q;
        frozen_nxt    = frozen;
        start_ready_o = 1'b0;
        tbl_rd_v_o    = 1'b0;
        cfg_v_o       = 1'b0;
        done_o        = 1'b0;
        error_o       = 1'b0;

        case (state)
            ST_IDLE: begin
                start_ready_o = 1'b1;
                if (start_v_i) begin
                    cfg_idx_nxt  = cfg_sel_i;
                    reg_idx_nxt  = '0;
                    core_idx_nxt = '0;
                    data_nxt     = '0;
                    frozen_nxt   = 1'b1;
                    state_nxt    = sel_bad ? ST_ERR : ST_SEND;
                end
            end
            ST_SEND: begin
                cfg_v_o = 1'b1;
                if (cfg_ready_i) begin
                    if (last_core) begin
                        core_idx_nxt = '0;
                        if (last_reg) begin
                            state_nxt = ST_DONE;
                        end else begin
                            reg_idx_nxt = reg_idx + REG_W'(1);
                            state_nxt   = ST_READ;
                        end
                    end else begin
                        core_idx_nxt = core_idx + CORE_W'(1);
                    end
                end
            end
            ST_READ: begin
                tbl_rd_v_o = 1'b1;
                state_nxt  = ST_LATCH;
            end
            ST_LATCH: begin
                data_nxt  = tbl_data_i;
                state_nxt = ST_SEND;
            end
            ST_DONE: begin
                done_o     = 1'b1;
                frozen_nxt = 1'b0;
                state_nxt  = ST_IDLE;
            end
            ST_ERR: begin
                error_o   = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Register 0 carries the hart id rather than table contents.
    assign cfg_core_o = core_idx;
    assign cfg_addr_o = cfg_addr_width_p'(reg_idx);
    assign cfg_data_o = (reg_idx == '0) ? cfg_data_width_p'(core_idx) : data_q;
    assign tbl_cfg_o  = cfg_idx;
    assign tbl_reg_o  = reg_idx;
    assign freeze_o   = {num_core_p{frozen}};

endmodule
`default_nettype wire

// File: tb/tb_bp_cfg_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_bp_cfg_loader
// Purpose  : Self-checking bench for bp_cfg_loader against a write-list model.
// Revision : 1.0
// ============================================================================
module tb_bp_cfg_loader;

    localparam int NC   = 4;
    localparam int NR   = 8;
    localparam int NCFG = 9;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start_v = 1'b0;
    logic [3:0]  cfg_sel = '0;
    logic        start_ready_o;
    logic        tbl_rd_v_o;
    logic [3:0]  tbl_cfg_o;
    logic [2:0]  tbl_reg_o;
    logic [63:0] tbl_data = '0;
    logic        cfg_v_o;
    logic [1:0]  cfg_core_o;
    logic [15:0] cfg_addr_o;
    logic [63:0] cfg_data_o;
    logic        cfg_ready = 1'b1;
    logic [3:0]  freeze_o;
    logic        done_o;
    logic        error_o;

    bp_cfg_loader dut (
        .clk_i         (clk),
        .reset_i       (reset),
        .start_v_i     (start_v),
        .cfg_sel_i     (cfg_sel),
        .start_ready_o (start_ready_o),
        .tbl_rd_v_o    (tbl_rd_v_o),
        .tbl_cfg_o     (tbl_cfg_o),
        .tbl_reg_o     (tbl_reg_o),
        .tbl_data_i    (tbl_data),
        .cfg_v_o       (cfg_v_o),
        .cfg_core_o    (cfg_core_o),
        .cfg_addr_o    (cfg_addr_o),
        .cfg_data_o    (cfg_data_o),
        .cfg_ready_i   (cfg_ready),
        .freeze_o      (freeze_o),
        .done_o        (done_o),
        .error_o       (error_o)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Table contents: config 2 yields 64'hA0+reg, other configs differ in byte 4.
    function automatic logic [63:0] tbl_fn(input int cfg, input int r);
        logic [7:0] a, b;
        a = 8'(cfg ^ 2);
        b = 8'hA0 + 8'(r);
        return {24'h0, a, 24'h0, b};
    endfunction

    always @(posedge clk) if (tbl_rd_v_o) tbl_data <= tbl_fn(int'(tbl_cfg_o), int'(tbl_reg_o));

    typedef struct {
        int          core;
        int          addr;
        logic [63:0] data;
    } wr_t;

    typedef enum int {M_IDLE, M_BUSY, M_DONE, M_ERR} mph_t;

    mph_t        ph = M_IDLE;
    wr_t         exp_q[$];
    wr_t         wlog[$];
    bit          exp_freeze = 1'b1;
    int          load_sel = 0;
    int          busy_cyc = 0;
    int          wr_cnt = 0;
    int          done_seen = 0;
    int          err_seen = 0;
    bit          prev_stall = 1'b0;
    logic [1:0]  prev_core;
    logic [15:0] prev_addr;
    logic [63:0] prev_data;

    // Reference model: a load is simply the ordered list of writes it must emit.
    always @(negedge clk) begin
        if (reset) begin
            chk("rst_cfg_v", 64'(cfg_v_o), 64'd0);
            chk("rst_tbl_rd", 64'(tbl_rd_v_o), 64'd0);
            chk("rst_freeze", 64'(freeze_o), 64'hF);
            chk("rst_ready", 64'(start_ready_o), 64'd1);
            chk("rst_done_err", 64'({done_o, error_o}), 64'd0);
            ph = M_IDLE;
            exp_q.delete();
            exp_freeze = 1'b1;
            prev_stall = 1'b0;
        end else begin
            chk("start_ready", 64'(start_ready_o), 64'(ph == M_IDLE));
            chk("done", 64'(done_o), 64'(ph == M_DONE));
            chk("error", 64'(error_o), 64'(ph == M_ERR));
            chk("freeze", 64'(freeze_o), exp_freeze ? 64'hF : 64'h0);
            if (ph != M_BUSY) begin
                chk("idle_cfg_v", 64'(cfg_v_o), 64'd0);
                chk("idle_tbl_rd", 64'(tbl_rd_v_o), 64'd0);
            end else begin
                busy_cyc++;
                if (prev_stall) begin
                    chk("stall_v", 64'(cfg_v_o), 64'd1);
                    chk("stall_core", 64'(cfg_core_o), 64'(prev_core));
                    chk("stall_addr", 64'(cfg_addr_o), 64'(prev_addr));
                    chk("stall_data", cfg_data_o, prev_data);
                end
                if (tbl_rd_v_o) begin
                    chk("rd_excl", 64'(cfg_v_o), 64'd0);
                    chk("rd_cfg", 64'(tbl_cfg_o), 64'(load_sel));
                    if (exp_q.size() > 0) chk("rd_reg", 64'(tbl_reg_o), 64'(exp_q[0].addr));
                end
                if (cfg_v_o) begin
                    if (exp_q.size() == 0) begin
                        chk("extra_write", 64'd1, 64'd0);
                    end else begin
                        chk("wr_core", 64'(cfg_core_o), 64'(exp_q[0].core));
                        chk("wr_addr", 64'(cfg_addr_o), 64'(exp_q[0].addr));
                        chk("wr_data", cfg_data_o, exp_q[0].data);
                    end
                end
                if (busy_cyc > 2000) begin
                    chk("load_watchdog", 64'(busy_cyc), 64'd2000);
                    exp_q.delete();
                    ph = M_IDLE;
                end
            end

            prev_stall = (ph == M_BUSY) && cfg_v_o && !cfg_ready;
            prev_core  = cfg_core_o;
            prev_addr  = cfg_addr_o;
            prev_data  = cfg_data_o;

            case (ph)
                M_IDLE: if (start_v) begin
                    exp_freeze = 1'b1;
                    load_sel   = int'(cfg_sel);
                    if (load_sel == 0 || load_sel >= NCFG) begin
                        ph = M_ERR;
                    end else begin
                        for (int r = 0; r < NR; r++)
                            for (int c = 0; c < NC; c++)
                                exp_q.push_back('{c, r, (r == 0) ? 64'(c) : tbl_fn(load_sel, r)});
                        busy_cyc = 0;
                        ph = M_BUSY;
                    end
                end
                M_ERR: begin
                    err_seen++;
                    ph = M_IDLE;
                end
                M_DONE: begin
                    done_seen++;
                    exp_freeze = 1'b0;
                    ph = M_IDLE;
                end
                M_BUSY: if (cfg_v_o && cfg_ready && exp_q.size() > 0) begin
                    wlog.push_back(exp_q.pop_front());
                    wr_cnt++;
                    if (exp_q.size() == 0) ph = M_DONE;
                end
                default: ph = M_IDLE;
            endcase
        end
    end

    bit rand_ready = 1'b0;

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_ready) cfg_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic do_start(input int sel);
        start_v = 1'b1;
        cfg_sel = 4'(sel);
        tick();
        start_v = 1'b0;
    endtask

    task automatic wait_idle(input int max_cyc);
        for (int i = 0; i < max_cyc; i++) begin
            if (start_ready_o) return;
            tick();
        end
        chk("wait_idle_timeout", 64'(start_ready_o), 64'd1);
    endtask

    int cyc, d0, e0, w0;

    initial begin
        repeat (3) tick();
        reset = 1'b0;
        repeat (5) tick();
        chk("idle_freeze", 64'(freeze_o), 64'hF);
        chk("idle_start_ready", 64'(start_ready_o), 64'd1);

        // Directed load, ready tied high.
        wlog.delete();
        d0 = done_seen;
        do_start(2);
        cyc = 1;
        while (!done_o && cyc < 200) begin
            tick();
            cyc++;
        end
        chk("done_cycle", 64'(cyc), 64'd47);
        tick();
        chk("freeze_after_done", 64'(freeze_o), 64'h0);
        chk("dir_writes", 64'(wlog.size()), 64'd32);
        if (wlog.size() == 32) begin
            chk("dir_w0_data", wlog[0].data, 64'd0);
            chk("dir_w3_core", 64'(wlog[3].core), 64'd3);
            chk("dir_w3_data", wlog[3].data, 64'd3);
            chk("dir_w4_addr", 64'(wlog[4].addr), 64'd1);
            chk("dir_w4_data", wlog[4].data, 64'hA1);
            chk("dir_w31_core", 64'(wlog[31].core), 64'd3);
            chk("dir_w31_addr", 64'(wlog[31].addr), 64'd7);
            chk("dir_w31_data", wlog[31].data, 64'hA7);
        end
        chk("dir_done_count", 64'(done_seen - d0), 64'd1);

        // Rejected indices: 0 and num_cfgs_p.
        repeat (2) begin
            static int bad_sel = 0;
            do_start(bad_sel);
            chk("err_pulse", 64'(error_o), 64'd1);
            chk("err_no_write", 64'(cfg_v_o), 64'd0);
            tick();
            chk("err_pulse_end", 64'(error_o), 64'd0);
            chk("err_freeze", 64'(freeze_o), 64'hF);
            bad_sel = NCFG;
        end

        // Random indices with ~50% backpressure.
        rand_ready = 1'b1;
        for (int it = 0; it < 8; it++) begin
            int sel;
            bit ok;
            sel = (it == 0) ? 7 : int'($urandom_range(0, 15));
            ok  = (sel >= 1 && sel < NCFG);
            d0 = done_seen; e0 = err_seen; w0 = wr_cnt;
            do_start(sel);
            wait_idle(3000);
            tick();
            chk("rnd_done_count", 64'(done_seen - d0), 64'(ok));
            chk("rnd_err_count", 64'(err_seen - e0), 64'(!ok));
            chk("rnd_writes", 64'(wr_cnt - w0), ok ? 64'd32 : 64'd0);
        end

        // Reset in the middle of a load, then a clean reload.
        d0 = done_seen; w0 = wr_cnt;
        do_start(5);
        for (int i = 0; i < 3000 && (wr_cnt - w0) < 13; i++) tick();
        chk("reset_point", 64'(wr_cnt - w0), 64'd13);
        reset = 1'b1;
        #1;
        chk("mid_rst_cfg_v", 64'(cfg_v_o), 64'd0);
        chk("mid_rst_freeze", 64'(freeze_o), 64'hF);
        chk("mid_rst_ready", 64'(start_ready_o), 64'd1);
        tick();
        tick();
        reset = 1'b0;
        tick();
        chk("mid_rst_no_done", 64'(done_seen - d0), 64'd0);
        w0 = wr_cnt;
        do_start(5);
        wait_idle(3000);
        tick();
        chk("reload_writes", 64'(wr_cnt - w0), 64'd32);
        chk("reload_done", 64'(done_seen - d0), 64'd1);

        // start held high through a whole load.
        rand_ready = 1'b0;
        cfg_ready  = 1'b1;
        d0 = done_seen; w0 = wr_cnt;
        start_v = 1'b1;
        cfg_sel = 4'd3;
        tick();
        for (int i = 0; i < 200 && !done_o; i++) tick();
        chk("held_done", 64'(done_o), 64'd1);
        tick();
        chk("held_idle_ready", 64'(start_ready_o), 64'd1);
        chk("held_unfrozen", 64'(freeze_o), 64'h0);
        tick();
        chk("held_refreeze", 64'(freeze_o), 64'hF);
        chk("held_busy", 64'(start_ready_o), 64'd0);
        start_v = 1'b0;
        wait_idle(3000);
        tick();
        chk("held_done_count", 64'(done_seen - d0), 64'd2);
        chk("held_writes", 64'(wr_cnt - w0), 64'd64);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
